// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction buffer between fetch and decode, 4 in / 4 out per cycle
module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [2:0]               in_num,
    input  logic [AW-1:0]            in_pc,
    input  logic [4*IW-1:0]          in_inst,
    output logic                     in_ready,
    output logic [3:0]               out_valid,
    output logic [4*IW-1:0]          out_inst,
    output logic [4*AW-1:0]          out_pc,
    input  logic [2:0]               pop_num,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] mem_pc   [DEPTH];
    logic [IW-1:0] mem_inst [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [2:0]    push_n;
    logic [CW-1:0] pop_c;
    logic [CW-1:0] pop_req;
    logic [CW-1:0] free_slots;
    logic          push_en;
    logic [CW-1:0] count_next;

    logic          wr_en   [4];
    logic [PW-1:0] wr_addr [4];
    logic [AW-1:0] wr_pc   [4];
    logic [PW-1:0] rd_addr [4];

    // Admission depends only on registered occupancy, so a same-cycle pop never opens the gate
    always_comb begin
        free_slots = DEPTH_C - count;
        in_ready   = (free_slots >= CW'(4));
    end

    // Clamp illegal bundle sizes and over-pops, then form the next occupancy
    always_comb begin
        push_n     = (in_num > 3'd4) ? 3'd4 : in_num;
        pop_req    = CW'(pop_num);
        pop_c      = (pop_req > count) ? count : pop_req;
        push_en    = in_valid && in_ready && !flush;
        count_next = count + (push_en ? CW'(push_n) : '0) - pop_c;
    end

    // Per-slot write address, enable and PC for the incoming bundle
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_en[k]   = push_en && (3'(k) < push_n);
            wr_addr[k] = tail + PW'(k);
            wr_pc[k]   = in_pc + AW'(4 * k);
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem_pc[wr_addr[k]]   <= wr_pc[k];
                mem_inst[wr_addr[k]] <= in_inst[k*IW +: IW];
            end
        end
    end

    // Pointer and occupancy update; flush dominates both push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) begin
                tail <= tail + PW'(push_n);
            end
            head  <= head + PW'(pop_c);
            count <= count_next;
        end
    end

    // Oldest four entries in program order, wrapping modulo DEPTH
    always_comb begin
        out_inst  = '0;
        out_pc    = '0;
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            rd_addr[k]            = head + PW'(k);
            out_valid[k]          = (count > CW'(k));
            out_inst[k*IW +: IW]  = mem_inst[rd_addr[k]];
            out_pc[k*AW +: AW]    = mem_pc[rd_addr[k]];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [2:0]   in_num;
    logic [31:0]  in_pc;
    logic [127:0] in_inst;
    logic         in_ready;
    logic [3:0]   out_valid;
    logic [127:0] out_inst;
    logic [127:0] out_pc;
    logic [2:0]   pop_num;
    logic [4:0]   count;

    int checks;
    int failures;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    fetch_queue #(.DEPTH(16), .IW(32), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .pop_num   (pop_num),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (in_num <= 3'd4) else $error("illegal in_num %0d", in_num);
            assert ({2'b00, pop_num} <= count) else $error("pop_num %0d exceeds count %0d", pop_num, count);
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_num   = 3'd0;
        pop_num  = 3'd0;
    endtask

    task automatic push(input logic [2:0] n, input logic [31:0] pc, input logic [2:0] pn);
        in_valid = 1'b1;
        in_num   = n;
        in_pc    = pc;
        in_inst  = {pc ^ 32'hDD, pc ^ 32'hCC, pc ^ 32'hBB, pc ^ 32'hAA};
        pop_num  = pn;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_pc    = '0;
        in_inst  = '0;
        idle();
        #12;
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        rst_n = 1'b1;
        step();

        // Full 4-wide bundle A..D at 0x1000
        push(3'd4, 32'h1000, 3'd0);
        in_inst = {32'hD, 32'hC, 32'hB, 32'hA};
        step();
        idle();
        check("b4_valid", 128'(out_valid), 128'hF);
        check("b4_pc", out_pc, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
        check("b4_inst", out_inst, {32'hD, 32'hC, 32'hB, 32'hA});
        check("b4_count", 128'(count), 128'd4);
        pop_num = 3'd4;
        step();
        idle();
        check("drain_count", 128'(count), 128'd0);
        check("drain_valid", 128'(out_valid), 128'h0);

        // Truncated bundles 2 then 3
        push(3'd2, 32'h2000, 3'd0);
        step();
        push(3'd3, 32'h3000, 3'd0);
        step();
        idle();
        check("trunc_count", 128'(count), 128'd5);
        check("trunc_pc", out_pc, {32'h3004, 32'h3000, 32'h2004, 32'h2000});
        pop_num = 3'd4;
        step();
        idle();
        check("trunc_rem_valid", 128'(out_valid), 128'h1);
        check("trunc_rem_pc", 128'(out_pc[31:0]), 128'h3008);

        // Simultaneous push 4 and pop 1
        push(3'd4, 32'h5000, 3'd1);
        step();
        idle();
        check("pp_count", 128'(count), 128'd4);
        check("pp_pc", out_pc, {32'h500C, 32'h5008, 32'h5004, 32'h5000});

        // Build count 9, then flush with push and pop pending
        push(3'd4, 32'h5010, 3'd0);
        step();
        push(3'd1, 32'h5020, 3'd0);
        step();
        idle();
        check("pre_flush_count", 128'(count), 128'd9);
        push(3'd4, 32'h9000, 3'd2);
        flush = 1'b1;
        step();
        idle();
        check("flush_count", 128'(count), 128'd0);
        check("flush_valid", 128'(out_valid), 128'h0);
        check("flush_ready", 128'(in_ready), 128'd1);
        step();
        check("flush_absent", 128'(count), 128'd0);

        // Fill to DEPTH, drop a fifth bundle, then pop
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 128'(in_ready), 128'd1);
            push(3'd4, 32'h6000 + 32'(i * 16), 3'd0);
            step();
        end
        idle();
        check("full_count", 128'(count), 128'd16);
        check("full_ready", 128'(in_ready), 128'd0);
        push(3'd4, 32'h7000, 3'd0);
        step();
        idle();
        check("drop_count", 128'(count), 128'd16);
        check("drop_pc", out_pc, {32'h600C, 32'h6008, 32'h6004, 32'h6000});
        pop_num = 3'd4;
        #1;
        check("pop_no_early_ready", 128'(in_ready), 128'd0);
        step();
        idle();
        check("after_pop_count", 128'(count), 128'd12);
        check("after_pop_ready", 128'(in_ready), 128'd1);
        check("after_pop_pc", 128'(out_pc[31:0]), 128'h6010);
        for (int i = 0; i < 3; i++) begin
            pop_num = 3'd4;
            step();
        end
        idle();
        check("empty_count", 128'(count), 128'd0);

        // Wrap-around: 20 pushes of 3 with pops of 3, scoreboard on every PC
        for (int i = 0; i <= 20; i++) begin
            idle();
            if (i < 20) begin
                push(3'd3, 32'h8000 + 32'(i * 256), 3'd0);
            end
            if (i > 0) begin
                for (int k = 0; k < 3; k++) begin
                    exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                    check("wrap_pc", 128'(out_pc[k*32 +: 32]), 128'(exp_pc));
                end
                pop_num = 3'd3;
            end
            if (i < 20) begin
                for (int k = 0; k < 3; k++) begin
                    sb.push_back(32'h8000 + 32'(i * 256) + 32'(4 * k));
                end
            end
            step();
        end
        idle();
        check("wrap_end_count", 128'(count), 128'd0);
        check("wrap_sb_empty", 128'(sb.size()), 128'd0);

        // Asynchronous reset mid-stream at count 7
        push(3'd4, 32'hA000, 3'd0);
        step();
        push(3'd3, 32'hA010, 3'd0);
        step();
        idle();
        check("pre_rst_count", 128'(count), 128'd7);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'h0);
        check("async_rst_count", 128'(count), 128'd0);
        #1;
        rst_n = 1'b1;
        push(3'd1, 32'h4000, 3'd0);
        step();
        idle();
        check("post_rst_pc", 128'(out_pc[31:0]), 128'h4000);
        check("post_rst_valid", 128'(out_valid), 128'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
